// File: rtl/bht_gshare_predictor.sv
// Gshare branch history table.
// Each entry holds one saturating counter. A predictor in fetch reads the
// table, and the resolve stage updates it. After reset, an init sweep writes
// INIT_CTR into every entry before the table accepts any requests.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweep writes INIT_CTR to entry[r_ptr]; requests ignored
// ST_RUN  | table live: predictions and updates accepted every cycle
module bht_gshare_predictor #(
  parameter int IDX_W    = 10,
  parameter int CTR_W    = 2,
  parameter int GHR_W    = 10,
  parameter int INIT_CTR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_ctr,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int               DEPTH      = 1 << IDX_W;
  localparam logic [CTR_W-1:0] L_CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] L_INIT     = CTR_W'(INIT_CTR);
  localparam logic [IDX_W-1:0] L_PTR_LAST = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_ready;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [CTR_W-1:0] r_pred_ctr;
  logic [IDX_W-1:0] r_pred_idx;
  logic [CTR_W-1:0] r_table [DEPTH];

  logic             w_run;
  logic             w_pred_acc;
  logic             w_upd_acc;
  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_hash_idx;
  logic [CTR_W-1:0] w_upd_old;
  logic [CTR_W-1:0] w_upd_new;
  logic [CTR_W-1:0] w_rd_ctr;

  assign w_run      = (r_state == ST_RUN);
  assign w_pred_acc = w_run & pred_valid;
  assign w_upd_acc  = w_run & upd_valid;

  // Global history: shifts in each resolved outcome. The history is absent when GHR_W is 0.
  generate
    if (GHR_W == 0) begin : g_no_ghr
      assign w_ghr_ext = '0;
    end else begin : g_ghr
      logic [GHR_W-1:0] r_ghr;
      logic [GHR_W-1:0] w_ghr_next;
      if (GHR_W == 1) begin : g_ghr1
        assign w_ghr_next = upd_taken;
      end else begin : g_ghrn
        assign w_ghr_next = {r_ghr[GHR_W-2:0], upd_taken};
      end
      // History register; it only moves on an accepted update.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ghr <= '0;
        end else if (w_upd_acc) begin
          r_ghr <= w_ghr_next;
        end
      end
      assign w_ghr_ext = IDX_W'(r_ghr);
    end
  endgenerate

  // Lookup index uses the history as it stood before this cycle's update.
  assign w_hash_idx = pred_pc ^ w_ghr_ext;
  assign w_upd_old  = r_table[upd_idx];

  // Saturating increment/decrement of the counter being updated.
  always_comb begin
    w_upd_new = w_upd_old;
    if (upd_taken) begin
      if (w_upd_old != L_CTR_MAX) w_upd_new = w_upd_old + CTR_W'(1);
    end else begin
      if (w_upd_old != '0) w_upd_new = w_upd_old - CTR_W'(1);
    end
  end

  // Write-first bypass: a same-cycle update to the looked-up entry is visible to the prediction.
  assign w_rd_ctr = (w_upd_acc && (upd_idx == w_hash_idx)) ? w_upd_new : r_table[w_hash_idx];

  // Table storage: the init sweep and the runtime updates share a single write port.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_table[r_ptr] <= L_INIT;
    end else if (upd_valid) begin
      r_table[upd_idx] <= w_upd_new;
    end
  end

  // Sequencer: sweep every entry once, then stay in RUN until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_ptr <= r_ptr + IDX_W'(1);
          if (r_ptr == L_PTR_LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_ptr   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Registered prediction result; the outputs hold until the next accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_ctr   <= '0;
      r_pred_idx   <= '0;
    end else begin
      r_pred_valid <= w_pred_acc;
      if (w_pred_acc) begin
        r_pred_idx   <= w_hash_idx;
        r_pred_ctr   <= w_rd_ctr;
        r_pred_taken <= w_rd_ctr[CTR_W-1];
      end
    end
  end

  assign ready          = r_ready;
  assign pred_out_valid = r_pred_valid;
  assign pred_taken     = r_pred_taken;
  assign pred_ctr       = r_pred_ctr;
  assign pred_idx       = r_pred_idx;

endmodule

// File: tb/tb_bht_gshare_predictor.sv
// Bench for bht_gshare_predictor: IDX_W=4, CTR_W=2, GHR_W=4, INIT_CTR=1.
module tb_bht_gshare_predictor;

  localparam int IDX_W = 4;
  localparam int CTR_W = 2;
  localparam int GHR_W = 4;
  localparam int INIT  = 1;
  localparam int N     = 1 << IDX_W;
  localparam int CMAX  = (1 << CTR_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             ready;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_pc;
  logic             pred_out_valid;
  logic             pred_taken;
  logic [CTR_W-1:0] pred_ctr;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  bht_gshare_predictor #(
    .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .INIT_CTR(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_ctr(pred_ctr), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: plain array of counter values plus history as an integer
  int m_ctr [N];
  int m_ghr;
  int m_last_idx;
  int m_last_ctr;

  typedef struct packed {
    logic             pv;
    logic [IDX_W-1:0] pc;
    logic             uv;
    logic [IDX_W-1:0] uidx;
    logic             ut;
    logic             ev;
    logic [IDX_W-1:0] eidx;
    logic [CTR_W-1:0] ectr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ctr[i] = INIT;
    m_ghr = 0;
    m_last_idx = 0;
    m_last_ctr = 0;
  endtask

  // Pulse requests during the sweep (they must be ignored) and measure ready latency.
  task automatic wait_ready(input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      pred_valid = 1'b1; pred_pc = IDX_W'($urandom_range(0, N-1));
      upd_valid  = 1'b1; upd_idx = IDX_W'($urandom_range(0, N-1)); upd_taken = 1'b1;
      @(posedge clk); #1;
      n++;
      chk({tag, "_no_valid_in_init"}, 32'(pred_out_valid), 0);
      if (ready) done = 1'b1;
    end
    idle();
    chk({tag, "_ready_latency"}, n, N);
    model_reset();
  endtask

  // One clock: drive inputs, advance the reference model, then compare.
  task automatic cycle(input bit pv, input int pc, input bit uv, input int uidx, input bit ut);
    int idx;
    int c;
    idx = (pc ^ m_ghr) % N;
    pred_valid = pv; pred_pc = IDX_W'(pc);
    upd_valid  = uv; upd_idx = IDX_W'(uidx); upd_taken = ut;
    if (uv) begin
      c = m_ctr[uidx];
      if (ut) c = (c < CMAX) ? c + 1 : CMAX;
      else    c = (c > 0) ? c - 1 : 0;
      m_ctr[uidx] = c;
      m_ghr = ((m_ghr * 2) + int'(ut)) % (1 << GHR_W);
    end
    if (pv) begin
      m_last_idx = idx;
      m_last_ctr = m_ctr[idx];
    end
    @(posedge clk); #1;
    chk("out_valid", 32'(pred_out_valid), 32'(pv));
    chk("pred_idx",  32'(pred_idx), m_last_idx);
    chk("pred_ctr",  32'(pred_ctr), m_last_ctr);
    chk("pred_taken", 32'(pred_taken), m_last_ctr / (1 << (CTR_W-1)));
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rows: pv pc uv uidx ut | ev eidx ectr   (all counters 1, history 0 at start)
    vecs[0] = '{1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 4'd0,  2'd1};
    vecs[1] = '{1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 2'd1};
    vecs[2] = '{1'b1, 4'd3,  1'b1, 4'd3, 1'b1, 1'b1, 4'd3,  2'd2};
    vecs[3] = '{1'b1, 4'd2,  1'b1, 4'd3, 1'b1, 1'b1, 4'd3,  2'd3};
    vecs[4] = '{1'b0, 4'd0,  1'b1, 4'd3, 1'b1, 1'b0, 4'd3,  2'd3};
    vecs[5] = '{1'b1, 4'd4,  1'b1, 4'd4, 1'b0, 1'b1, 4'd3,  2'd3};
    vecs[6] = '{1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4,  2'd0};
    vecs[7] = '{1'b1, 4'd10, 1'b1, 4'd4, 1'b0, 1'b1, 4'd4,  2'd0};

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_valid", 32'(pred_out_valid), 0);
    chk("rst_taken", 32'(pred_taken), 0);
    chk("rst_ctr",   32'(pred_ctr), 0);
    chk("rst_idx",   32'(pred_idx), 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("first");

    for (int i = 0; i < 8; i++) begin
      pred_valid = vecs[i].pv; pred_pc = vecs[i].pc;
      upd_valid  = vecs[i].uv; upd_idx = vecs[i].uidx; upd_taken = vecs[i].ut;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(pred_out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_idx", i),   32'(pred_idx), 32'(vecs[i].eidx));
      chk($sformatf("vec%0d_ctr", i),   32'(pred_ctr), 32'(vecs[i].ectr));
      chk($sformatf("vec%0d_taken", i), 32'(pred_taken), 32'(vecs[i].ectr[CTR_W-1]));
      idle();
    end

    // reset during run, then again mid-sweep at pointer 7
    rst_n = 1'b0;
    #1;
    chk("runrst_ready", 32'(ready), 0);
    chk("runrst_valid", 32'(pred_out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("midsweep_ready", 32'(ready), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("resweep");

    // every counter back to INIT, history cleared (index equals pc)
    for (int pc = 0; pc < N; pc++) cycle(1'b1, pc, 1'b0, 0, 1'b0);

    // history T, NT, T -> 0101; pc 0011 hashes to 0110
    cycle(1'b0, 0, 1'b1, 9, 1'b1);
    cycle(1'b0, 0, 1'b1, 9, 1'b0);
    cycle(1'b0, 0, 1'b1, 9, 1'b1);
    cycle(1'b1, 3, 1'b0, 0, 1'b0);
    chk("ghr_hash_idx", 32'(pred_idx), 6);

    // saturation at both ends on entry 5
    repeat (4) cycle(1'b0, 0, 1'b1, 5, 1'b1);
    cycle(1'b1, 5 ^ m_ghr, 1'b0, 0, 1'b0);
    chk("sat_hi_ctr", 32'(pred_ctr), 3);
    chk("sat_hi_taken", 32'(pred_taken), 1);
    repeat (4) cycle(1'b0, 0, 1'b1, 5, 1'b0);
    cycle(1'b1, 5 ^ m_ghr, 1'b0, 0, 1'b0);
    chk("sat_lo_ctr", 32'(pred_ctr), 0);

    // random traffic, frequently colliding the update with the lookup index
    for (int k = 0; k < 400; k++) begin
      int pc;
      int ui;
      pc = $urandom_range(0, N-1);
      ui = ($urandom_range(0, 1) == 1) ? ((pc ^ m_ghr) % N) : $urandom_range(0, N-1);
      cycle(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), ui, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bht_gshare_predictor.md
Name: bht_gshare_predictor

Overview:
- Parametrised successor to the fixed 1024 x 2-bit branch history table and its single global 2-bit predictor FSM.
- Holds one saturating counter per table entry. The table is indexed gshare-style: the PC index bits are XORed with a global history register (GHR).
- A registered prediction port and a non-speculative update port serve the fetch and resolve stages.
- A built-in init sequencer clears the table after reset, so no initial blocks are required.

Parameters:
IDX_W, 10, table index width; table depth = 2**IDX_W entries
CTR_W, 2, saturating counter width (>=1)
GHR_W, 10, global history length, 0..IDX_W; 0 = plain per-PC indexing (no history)
INIT_CTR, 0, value written into every counter by the init sweep (< 2**CTR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ready  out  1  high once init sweep complete; table accepts requests only when high
pred_valid  in  1  prediction request strobe
pred_pc  in  IDX_W  low PC index bits of branch being fetched
pred_out_valid  out  1  prediction result valid (one cycle after accepted request)
pred_taken  out  1  predicted direction = MSB of counter
pred_ctr  out  CTR_W  full counter value used for prediction
pred_idx  out  IDX_W  hashed table index used; caller returns it on upd_idx
upd_valid  in  1  branch resolution strobe
upd_idx  in  IDX_W  table index to update (pred_idx captured at prediction time)
upd_taken  in  1  actual branch outcome

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to INIT, sweep pointer = 0, GHR = 0, ready = 0.
  - pred_out_valid = 0, pred_taken = 0, pred_ctr = 0, pred_idx = 0.
  - Table contents are not reset directly.
- FSM INIT:
  - Each cycle writes INIT_CTR to entry[ptr] and increments ptr.
  - Once entry 2**IDX_W-1 is written, the next state is RUN and ready goes 1 on the following cycle.
  - Total: exactly 2**IDX_W cycles from first clk edge after rst_n rises to ready = 1.
- While ready = 0:
  - pred_valid and upd_valid are ignored; GHR is unchanged and pred_out_valid stays 0.
- FSM RUN:
  - Stays in RUN until rst_n is asserted.
  - Asserting rst_n mid-sweep or mid-run restarts the sweep from 0.
- Hash:
  - idx = pred_pc XOR zero-extended GHR, using the GHR value before any same-cycle update.
  - With GHR_W = 0, idx = pred_pc.
- Prediction (RUN, pred_valid sampled high at edge N):
  - After edge N+1, pred_out_valid = 1 and pred_idx = idx.
  - pred_ctr = counter value, pred_taken = pred_ctr[CTR_W-1].
  - Outputs hold until the next accepted request; pred_out_valid is 1 for exactly one cycle per request.
- Update (RUN, upd_valid sampled high):
  - entry[upd_idx] increments if upd_taken, else decrements.
  - Saturates at 2**CTR_W-1 and at 0 (no wrap).
  - In the same edge, GHR <= {GHR[GHR_W-2:0], upd_taken}; for GHR_W = 1, GHR <= upd_taken; for GHR_W = 0, no GHR.
- Read-during-write:
  - If a prediction and an update hit the same index in the same cycle, the prediction returns the post-update counter (write-first bypass).
  - Different indices are independent.
- Back-to-back:
  - A request and an update are both accepted every cycle; there is no stall and no backpressure.
  - Two updates to the same index on consecutive cycles must both take effect.

Test Plan:
- IDX_W=4, INIT_CTR=1: release rst_n -> ready rises exactly 16 cycles later; predicting every index 0..15 returns pred_ctr=1, pred_taken=0.
- IDX_W=4, GHR_W=0, CTR_W=2, INIT_CTR=0: update idx 5 taken x4, then predict pc 5 -> pred_ctr=3 (saturated), pred_taken=1; then 4 not-taken updates -> pred_ctr=0, no wrap to 3.
- Same-cycle update(idx 3, taken) and predict(pc 3), counter at 1 -> next cycle pred_ctr=2, pred_taken=1 (bypass).
- GHR_W=4, GHR=0: updates taken, not-taken, taken (GHR=4'b0101), then predict pc 4'b0011 -> pred_idx=4'b0110.
- Assert rst_n low at sweep pointer 7 after counters were modified -> ready=0 immediately; sweep restarts; ready rises 16 cycles after release; all counters = INIT_CTR; GHR = 0.
- pred_valid/upd_valid pulsed while ready=0 -> no pred_out_valid; after ready, counters = INIT_CTR and GHR = 0.
